dir_input_conditioner: RTL and testbench
========================================

# dir_input_conditioner

Input stage feeding the snake movement engine. Four raw direction buttons are synchronised and debounced, and each press is reduced to a single one-hot request. The request is held as pending until the game step tick, and illegal 180° reversals are filtered out. The output `movement` is a clean, held one-hot direction that the movement engine samples on every clock.

## Interface
Parameters:
- `DEBOUNCE_CYCLES`, default 50000: consecutive stable samples needed to accept a level change; must be ≥ 1.

Ports:
- `clk`  in  1  system clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `btn_raw`  in  4  asynchronous buttons: bit0 UP, bit1 DOWN, bit2 LEFT, bit3 RIGHT; active-high.
- `step`  in  1  one-`clk`-cycle pulse per game tick; commits the pending request.
- `movement`  out  4  committed direction: one-hot UP=1, DOWN=2, LEFT=4, RIGHT=8, or 0 (none yet).
- `pending`  out  4  accepted but uncommitted request, one-hot or 0.
- `press_pulse`  out  1  one-cycle strobe on every accepted press.
- `btn_level`  out  4  debounced button levels.

## Operation
- Each bit passes through a 2-FF synchroniser and then a debouncer.
- Debouncer behaviour:
  - When the synchronised level differs from `btn_level[i]`, the counter increments.
  - When the counter reaches `DEBOUNCE_CYCLES`, `btn_level[i]` takes the new level and the counter clears.
  - Any sample equal to `btn_level[i]` clears the counter.
- Rising edges of `btn_level` are candidate presses. Falling edges are ignored.
- Several simultaneous rising edges: only one is kept, priority UP > DOWN > LEFT > RIGHT.
- Candidate acceptance:
  - A candidate is accepted unless it is rejected by the reversal filter (see Configuration).
  - An accepted candidate overwrites `pending` (last press wins) and pulses `press_pulse`.
- On `step`:
  - If `pending` ≠ 0: `movement` ← `pending` and `pending` ← 0.
  - Otherwise `movement` holds.
- `step` and an accepted candidate in the same cycle: the candidate goes directly to `movement` and `pending` ← 0. The older pending request is discarded.
- Reversal checks always compare against the current `movement` (pre-edge value).
- `movement` never returns to 0 after the first commit, except through `reset`.

## Timing
- Reset values: `movement`=0, `pending`=0, `press_pulse`=0, `btn_level`=0. Synchronisers and counters also clear to 0.
- Latency from a raw edge held steady to the `btn_level` change is 2 + `DEBOUNCE_CYCLES` cycles.
- `press_pulse` and the `pending` update occur on the clock edge following the `btn_level` rise, i.e. one cycle later.
- A `step` at cycle N updates `movement` at the edge ending cycle N; it is visible in cycle N+1.
- `step` held high for multiple cycles is treated as one commit per high cycle. Upstream guarantees single-cycle pulses.
- Glitches shorter than `DEBOUNCE_CYCLES` samples produce no output change.
- `reset` asserted mid-debounce or with a request pending: all state clears on that edge. A button still held after reset is seen as a new press once debounced.
- Counter width is $clog2(`DEBOUNCE_CYCLES`+1); no wrap is possible.

## Configuration
- Macro `SNAKE_REVERSAL_FILTER_EN`.
- Defined: a candidate exactly opposite the current `movement` is rejected. UP↔DOWN and LEFT↔RIGHT are opposites. A rejected candidate causes no `press_pulse` and no `pending` change.
- Undefined: every candidate is accepted; reversal policy is left to the movement engine.
- With `movement`=0, nothing is ever rejected.

## Structure
- Shared package `snake_pkg` holds:
  - the direction constants `UP`, `DOWN`, `LEFT`, `RIGHT`;
  - typedef `dir_t` (4-bit one-hot);
  - function `dir_opposite(dir_t)`.
- One sub-module, `btn_debounce`, contains the synchroniser, counter and level register for a single bit. It is instantiated 4×.
- Priority selection, the reversal filter, the pending register and the commit logic live in the top module.

## Test plan
Benches use `DEBOUNCE_CYCLES`=4.
- Reset: after a `reset` pulse, all outputs are 0 while `btn_raw`=4'b0001 is held. `btn_level`=1 appears 6 cycles after reset deasserts.
- Debounce: RIGHT asserted for 3 cycles, then dropped → no `press_pulse` and `btn_level` stays 0. Held for 6 cycles → `btn_level`[3]=1, one `press_pulse`, `pending`=8.
- Commit: with `pending`=8, pulse `step` → next cycle `movement`=8 and `pending`=0. A second `step` → `movement` stays 8.
- Priority and overwrite: UP and LEFT rise together → `pending`=1. A later LEFT press before `step` → `pending`=4.
- Reversal with the macro defined and `movement`=8: a LEFT press gives no `press_pulse` and `pending` stays 0. Without the macro: `pending`=4.
- Same-cycle collision: `pending`=2 and `step` coincide with an accepted LEFT candidate → `movement`=4 and `pending`=0.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared snake-game types: one-hot direction encoding and its opposite.
package snake_pkg;

    typedef logic [3:0] dir_t;

    localparam dir_t NONE  = 4'b0000;
    localparam dir_t UP    = 4'b0001;
    localparam dir_t DOWN  = 4'b0010;
    localparam dir_t LEFT  = 4'b0100;
    localparam dir_t RIGHT = 4'b1000;

    function automatic dir_t dir_opposite(input dir_t d);
        dir_t r;
        case (d)
            UP:      r = DOWN;
            DOWN:    r = UP;
            LEFT:    r = RIGHT;
            RIGHT:   r = LEFT;
            default: r = NONE;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dir_input_conditioner_debounce.sv
// btn_debounce: 2-FF synchroniser, stability counter and debounced level for one button.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic [CW-1:0] cnt;

    // Level flips on the sample that would bring the count to DEBOUNCE_CYCLES,
    // so the counter itself never has to hold that value.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q    <= '0;
            cnt       <= '0;
            btn_level <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], btn_raw};
            if (sync_q[1] == btn_level) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                btn_level <= sync_q[1];
                cnt       <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/dir_input_conditioner.sv
// Debounced direction buttons -> single pending request -> committed movement on step.
// Optional macro SNAKE_REVERSAL_FILTER_EN rejects presses opposite the current movement.
module dir_input_conditioner
    import snake_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] btn_raw,
    input  logic       step,
    output logic [3:0] movement,
    output logic [3:0] pending,
    output logic       press_pulse,
    output logic [3:0] btn_level
);

    logic [3:0] level_d;
    logic [3:0] rise;
    dir_t       cand;
    logic       reject;
    logic       accept;

    for (genvar g = 0; g < 4; g++) begin : g_btn
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk      (clk),
            .reset    (reset),
            .btn_raw  (btn_raw[g]),
            .btn_level(btn_level[g])
        );
    end

    assign rise = btn_level & ~level_d;

    always_comb begin
        cand = NONE;
        if (rise[0])      cand = UP;
        else if (rise[1]) cand = DOWN;
        else if (rise[2]) cand = LEFT;
        else if (rise[3]) cand = RIGHT;
    end

`ifdef SNAKE_REVERSAL_FILTER_EN
    assign reject = (movement != NONE) && (cand == dir_opposite(movement));
`else
    assign reject = 1'b0;
`endif

    assign accept = (cand != NONE) && !reject;

    // A press landing on a step bypasses pending and supersedes any older request.
    always_ff @(posedge clk) begin
        if (reset) begin
            level_d     <= '0;
            movement    <= '0;
            pending     <= '0;
            press_pulse <= 1'b0;
        end else begin
            level_d     <= btn_level;
            press_pulse <= accept;
            if (step && accept) begin
                movement <= cand;
                pending  <= '0;
            end else if (step) begin
                if (pending != NONE) movement <= pending;
                pending <= '0;
            end else if (accept) begin
                pending <= cand;
            end
        end
    end

endmodule

// File: tb/tb_dir_input_conditioner.sv
// Directed scoreboard bench for dir_input_conditioner with DEBOUNCE_CYCLES=4.
module tb_dir_input_conditioner;

    localparam int SEL_MOV = 0;
    localparam int SEL_PEN = 1;
    localparam int SEL_PUL = 2;
    localparam int SEL_LVL = 3;

    typedef struct {
        string      tag;
        int         sel;
        logic [3:0] exp;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] btn_raw;
    logic       step;
    logic [3:0] movement;
    logic [3:0] pending;
    logic       press_pulse;
    logic [3:0] btn_level;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    dir_input_conditioner #(
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .btn_raw    (btn_raw),
        .step       (step),
        .movement   (movement),
        .pending    (pending),
        .press_pulse(press_pulse),
        .btn_level  (btn_level)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push(input string tag, input int sel, input logic [3:0] v);
        exp_t e;
        e.tag = tag;
        e.sel = sel;
        e.exp = v;
        sb.push_back(e);
    endtask

    function automatic logic [3:0] observe(input int sel);
        case (sel)
            SEL_MOV: return movement;
            SEL_PEN: return pending;
            SEL_PUL: return {3'b000, press_pulse};
            default: return btn_level;
        endcase
    endfunction

    task automatic drain();
        exp_t       e;
        logic [3:0] o;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            o = observe(e.sel);
            checks++;
            assert (o === e.exp) else begin
                errors++;
                $error("FAIL %s: got %0h expected %0h", e.tag, o, e.exp);
            end
        end
    endtask

    task automatic push_all_zero(input string tag);
        push({tag, "_mov"}, SEL_MOV, 4'h0);
        push({tag, "_pen"}, SEL_PEN, 4'h0);
        push({tag, "_pul"}, SEL_PUL, 4'h0);
        push({tag, "_lvl"}, SEL_LVL, 4'h0);
    endtask

    initial begin
        reset   = 1'b1;
        btn_raw = 4'b0001;
        step    = 1'b0;
        cyc(2);
        push_all_zero("rst_hold");
        drain();

        // UP held through reset: level appears 6 cycles after release of reset
        reset = 1'b0;
        cyc(5);
        push("rst_lvl_early", SEL_LVL, 4'h0);
        drain();
        cyc(1);
        push("rst_lvl", SEL_LVL, 4'h1);
        drain();

        reset   = 1'b1;
        btn_raw = 4'b0000;
        cyc(1);
        reset = 1'b0;
        push_all_zero("rst2");
        drain();

        // 3-cycle RIGHT glitch is filtered
        btn_raw = 4'b1000;
        cyc(3);
        btn_raw = 4'b0000;
        for (int i = 0; i < 8; i++) begin
            cyc(1);
            push("glitch_lvl", SEL_LVL, 4'h0);
            push("glitch_pul", SEL_PUL, 4'h0);
            drain();
        end

        // RIGHT held: accepted press
        btn_raw = 4'b1000;
        cyc(5);
        push("right_lvl_early", SEL_LVL, 4'h0);
        drain();
        cyc(1);
        push("right_lvl", SEL_LVL, 4'h8);
        push("right_pul_early", SEL_PUL, 4'h0);
        drain();
        cyc(1);
        push("right_pul", SEL_PUL, 4'h1);
        push("right_pen", SEL_PEN, 4'h8);
        drain();
        cyc(1);
        push("right_pul_once", SEL_PUL, 4'h0);
        push("right_mov0", SEL_MOV, 4'h0);
        drain();

        // Commit
        step = 1'b1;
        cyc(1);
        step = 1'b0;
        push("commit_mov", SEL_MOV, 4'h8);
        push("commit_pen", SEL_PEN, 4'h0);
        drain();
        step = 1'b1;
        cyc(1);
        step = 1'b0;
        push("commit2_mov", SEL_MOV, 4'h8);
        drain();

        // Reversal: LEFT against movement RIGHT
        btn_raw = 4'b0000;
        cyc(8);
        btn_raw = 4'b0100;
        cyc(7);
`ifdef SNAKE_REVERSAL_FILTER_EN
        push("rev_pul", SEL_PUL, 4'h0);
        push("rev_pen", SEL_PEN, 4'h0);
`else
        push("rev_pul", SEL_PUL, 4'h1);
        push("rev_pen", SEL_PEN, 4'h4);
`endif
        push("rev_mov", SEL_MOV, 4'h8);
        drain();

        reset   = 1'b1;
        btn_raw = 4'b0000;
        cyc(1);
        reset = 1'b0;
        push_all_zero("rst3");
        drain();

        // Priority UP over LEFT, then a later LEFT overwrites
        btn_raw = 4'b0101;
        cyc(7);
        push("prio_pen", SEL_PEN, 4'h1);
        push("prio_pul", SEL_PUL, 4'h1);
        drain();
        btn_raw = 4'b0001;
        cyc(8);
        btn_raw = 4'b0101;
        cyc(7);
        push("ovw_pen", SEL_PEN, 4'h4);
        push("ovw_pul", SEL_PUL, 4'h1);
        drain();

        btn_raw = 4'b0000;
        cyc(8);
        push("fall_pen", SEL_PEN, 4'h4);
        drain();
        btn_raw = 4'b0010;
        cyc(7);
        push("down_pen", SEL_PEN, 4'h2);
        drain();

        // Step coinciding with a LEFT candidate
        btn_raw = 4'b0000;
        cyc(8);
        btn_raw = 4'b0100;
        cyc(6);
        step = 1'b1;
        cyc(1);
        step = 1'b0;
        push("coll_mov", SEL_MOV, 4'h4);
        push("coll_pen", SEL_PEN, 4'h0);
        push("coll_pul", SEL_PUL, 4'h1);
        drain();

        // Step with nothing pending holds movement
        step = 1'b1;
        cyc(1);
        step = 1'b0;
        push("hold_mov", SEL_MOV, 4'h4);
        drain();

        // Reset mid-debounce clears everything
        btn_raw = 4'b0000;
        cyc(8);
        btn_raw = 4'b0010;
        cyc(4);
        reset = 1'b1;
        cyc(1);
        reset = 1'b0;
        push_all_zero("rst_mid");
        drain();
        cyc(6);
        push("post_rst_lvl", SEL_LVL, 4'h2);
        drain();
        cyc(1);
        push("post_rst_pen", SEL_PEN, 4'h2);
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
